fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter XLEN, default 32: address/PC width in bits; instruction width fixed at 32.
REQ-002 Parameter DEPTH, default 4: fetch queue entries; power of two, 2..16.
REQ-003 Parameter RESET_ADDR, default 32'h00000000: PC value after reset; bits [1:0] must be zero.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 imem_req  output  1  fetch request issued this cycle.
REQ-007 imem_addr  output  XLEN  word-aligned fetch address, valid with imem_req.
REQ-008 imem_rvalid  input  1  read data valid; asserted exactly one cycle after imem_req.
REQ-009 imem_rdata  input  32  instruction word returned with imem_rvalid.
REQ-010 redirect_valid  input  1  branch/jump/trap redirect request.
REQ-011 redirect_addr  input  XLEN  redirect target; bits [1:0] ignored.
REQ-012 out_valid  output  1  queue head holds a valid instruction.
REQ-013 out_ready  input  1  consumer accepts head this cycle.
REQ-014 out_pc  output  XLEN  PC of head instruction.
REQ-015 out_instr  output  32  head instruction word.

Function
REQ-016 PC register holds next fetch address; imem_addr = PC; PC advances by 4 on each issued request, wrapping modulo 2^XLEN.
REQ-017 imem_req asserted iff not reset, no redirect this cycle, and (queue occupancy + in-flight responses) < DEPTH; at most one request in flight.
REQ-018 Response with imem_rvalid pushes {issuing PC, imem_rdata} into queue tail, unless discarded per REQ-021.
REQ-019 Queue is FIFO; pop when out_valid && out_ready; out_valid = occupancy != 0; out_pc/out_instr driven from head register (no combinational path from imem_rdata).
REQ-020 Push and pop in same cycle: occupancy unchanged, both take effect; full queue never overflows (guaranteed by REQ-017), empty queue never underflows.
REQ-021 redirect_valid: next cycle PC = {redirect_addr[XLEN-1:2],2'b00}, queue empty, in-flight response (if any) discarded via epoch bit toggle; no request issued in redirect cycle.
REQ-022 Redirect has priority over pop/push in same cycle; head handshake in redirect cycle is void and consumer must not commit it.
REQ-023 Back-to-back redirects: last one wins; each discards all prior in-flight data.
REQ-024 Steady state with out_ready=1: one instruction per cycle after 2-cycle initial latency (request cycle + response push cycle).

Reset
REQ-025 During reset: PC = RESET_ADDR, queue empty, out_valid=0, imem_req=0, epoch=0, in-flight flag cleared; out_pc/out_instr = 0.
REQ-026 Reset asserted mid-fetch: returning imem_rvalid in the cycle after reset deassertion is discarded.
REQ-027 First imem_req with imem_addr=RESET_ADDR in first cycle after reset deasserts.

Configuration
REQ-028 Macro FETCH_UNIT_PERF_EN defined: adds outputs perf_fetched (32, instructions popped) and perf_flushed (32, entries+in-flight discarded by redirects), both reset to 0, saturating at 32'hFFFFFFFF.
REQ-029 Macro undefined: perf ports and counters absent; all other behaviour identical.

Structure
REQ-030 Package riscv_pkg holds XLEN default, INSTR_NOP (32'h00000013), RESET_ADDR default, and typedef fetch_entry_t {pc, instr}.
REQ-031 Queue is a sub-module sync_fifo parametrised on entry type width and DEPTH, with flush input; fetch_unit instantiates one.

Verification
REQ-032 Reset, out_ready=1, imem returns 0x00000013 per address -> imem_addr 0x0,0x4,0x8...; first out_valid on cycle 2 with out_pc=0x0, then one per cycle.
REQ-033 out_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 entries queued, imem_req low thereafter, no data lost; out_ready=1 -> PCs 0x0..0xC pop in order.
REQ-034 Redirect to 0x103 while a request in flight and queue holds 2 -> next cycle queue empty, imem_addr=0x100, stale response not pushed, next out_pc=0x100.
REQ-035 Redirect and out_ready both high in same cycle with valid head -> queue flushed, perf_fetched (PERF_EN) not incremented for that head.
REQ-036 PC=0xFFFFFFFC fetch -> next imem_addr=0x00000000 (wrap).
REQ-037 Reset asserted for one cycle mid-stream -> out_valid=0 next cycle, fetch restarts at RESET_ADDR, pending response ignored.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared fetch-path definitions: default widths/addresses, the NOP encoding,
// the fetch queue entry layout and a saturating counter helper.
package riscv_pkg;

  localparam int unsigned  DEF_XLEN       = 32;
  localparam logic [31:0]  INSTR_NOP      = 32'h0000_0013;
  localparam logic [31:0]  DEF_RESET_ADDR = 32'h0000_0000;

  // One fetch queue entry at the default XLEN
  typedef struct packed {
    logic [DEF_XLEN-1:0] pc;
    logic [31:0]         instr;
  } fetch_entry_t;

  // 32-bit add that sticks at all-ones instead of wrapping
  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush; head entry is read straight from the storage
// registers and forced to zero while empty.
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   flush           drops all entries (wins over push/pop)
//   push/push_data  write tail
//   pop             retire head
//   head_data       current head entry (zero when empty)
//   count           current occupancy
module sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_pop   = pop && !flush && !w_empty;
  // A full queue may still accept when the head leaves in the same cycle
  assign w_push  = push && !flush && (!w_full || w_pop);

  // Pointer/occupancy tracking; DEPTH is a power of two so pointers wrap naturally
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage; contents are don't-care outside the valid window
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= push_data;
  end

  assign head_data = w_empty ? '0 : r_mem[r_rd_ptr];
  assign count     = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC generation, single outstanding imem request,
// response queue toward decode, and redirect (flush) handling.
// Optional feature macro: FETCH_UNIT_PERF_EN adds perf_fetched/perf_flushed.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   imem_req/imem_addr              fetch request and word-aligned address
//   imem_rvalid/imem_rdata          response, exactly one cycle after request
//   redirect_valid/redirect_addr    branch/jump/trap redirect
//   out_valid/out_ready             head handshake toward the consumer
//   out_pc/out_instr                head instruction and its PC
//   perf_fetched/perf_flushed       (macro only) popped / discarded counts
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int unsigned    XLEN       = DEF_XLEN,
  parameter int unsigned    DEPTH      = 4,
  parameter logic [XLEN-1:0] RESET_ADDR = XLEN'(DEF_RESET_ADDR)
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_addr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_instr
`ifdef FETCH_UNIT_PERF_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_flushed
`endif
);

  localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
  localparam int unsigned OCC_W   = CNT_W + 1;
  localparam int unsigned ENTRY_W = XLEN + 32;

  logic [XLEN-1:0]    r_pc;
  logic               r_inflight;
  logic [XLEN-1:0]    r_inflight_pc;
  logic               r_inflight_epoch;
  logic               r_epoch;

  logic [CNT_W-1:0]   w_count;
  logic [ENTRY_W-1:0] w_head;
  logic [OCC_W-1:0]   w_occ;
  logic               w_resp_ok;
  logic               w_push;
  logic               w_pop;
  logic               w_unused;

  // Low address bits of a redirect target are dropped by alignment
  assign w_unused = &{1'b0, redirect_addr[1:0]};

  // Queued entries plus the outstanding response must stay within DEPTH
  assign w_occ    = OCC_W'(w_count) + OCC_W'(r_inflight);
  assign imem_req = !reset && !redirect_valid && (w_occ < OCC_W'(DEPTH));
  assign imem_addr = r_pc;

  // A response counts only if it belongs to the current epoch
  assign w_resp_ok = imem_rvalid && r_inflight && (r_inflight_epoch == r_epoch);
  assign w_push    = w_resp_ok && !redirect_valid;

  // A head handshake coinciding with a redirect is void
  assign out_valid = (w_count != '0);
  assign w_pop     = out_valid && out_ready && !redirect_valid;

  // PC, outstanding-request tracking and epoch
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc             <= RESET_ADDR;
      r_inflight       <= 1'b0;
      r_inflight_pc    <= '0;
      r_inflight_epoch <= 1'b0;
      r_epoch          <= 1'b0;
    end else begin
      if (redirect_valid) begin
        r_pc    <= {redirect_addr[XLEN-1:2], 2'b00};
        r_epoch <= ~r_epoch;
      end else if (imem_req) begin
        r_pc <= r_pc + XLEN'(4);
      end
      r_inflight <= imem_req;
      if (imem_req) begin
        r_inflight_pc    <= r_pc;
        r_inflight_epoch <= r_epoch;
      end
    end
  end

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (w_push),
    .push_data ({r_inflight_pc, imem_rdata}),
    .pop       (w_pop),
    .head_data (w_head),
    .count     (w_count)
  );

  assign out_pc    = w_head[ENTRY_W-1:32];
  assign out_instr = w_head[31:0];

`ifdef FETCH_UNIT_PERF_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_flushed;
  logic [31:0] w_flush_cnt;

  // Discarded work on a redirect: every queued entry plus a returning response
  assign w_flush_cnt = redirect_valid ? (32'(w_count) + 32'(w_resp_ok)) : 32'h0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_fetched <= 32'h0;
      r_perf_flushed <= 32'h0;
    end else begin
      if (w_pop)          r_perf_fetched <= sat_add32(r_perf_fetched, 32'd1);
      if (redirect_valid) r_perf_flushed <= sat_add32(r_perf_flushed, w_flush_cnt);
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_flushed = r_perf_flushed;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, a back-to-back redirect
// sequence, then random traffic against a queue-based reference model.
module tb_fetch_unit;
  import riscv_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RST_A = 32'h0;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
`ifdef FETCH_UNIT_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_flushed;
`endif

  always #5 clk = ~clk;

  fetch_unit #(.XLEN(32), .DEPTH(DEPTH), .RESET_ADDR(RST_A)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr)
`ifdef FETCH_UNIT_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_flushed   (perf_flushed)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction memory contents
  bit nop_mode = 1'b1;
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return nop_mode ? INSTR_NOP : ((a ^ 32'hC0DE_0000) + 32'h13);
  endfunction

  // Reference model: PC, pending response and a plain queue of entries
  fetch_entry_t mq[$];
  logic [31:0]  m_pc = RST_A;
  bit           m_infl = 1'b0;
  logic [31:0]  m_infl_pc = '0;
  logic [31:0]  m_fetched = '0;
  logic [31:0]  m_flushed = '0;

  function automatic void model_step();
    int sz;
    bit req;
    fetch_entry_t e;
    sz = mq.size();
    if (reset) begin
      mq.delete();
      m_pc = RST_A; m_infl = 0; m_fetched = 0; m_flushed = 0;
    end else if (redirect_valid) begin
      m_flushed += 32'(sz) + 32'(m_infl && imem_rvalid);
      mq.delete();
      m_pc = {redirect_addr[31:2], 2'b00};
      m_infl = 0;
    end else begin
      req = (sz + int'(m_infl)) < int'(DEPTH);
      if (sz != 0 && out_ready) begin
        void'(mq.pop_front());
        m_fetched++;
      end
      if (m_infl && imem_rvalid) begin
        e.pc = m_infl_pc; e.instr = imem_rdata;
        mq.push_back(e);
      end
      m_infl = req;
      if (req) begin
        m_infl_pc = m_pc;
        m_pc += 32'd4;
      end
    end
  endfunction

  task automatic model_check();
    int sz;
    bit ereq;
    sz = mq.size();
    ereq = !reset && !redirect_valid && ((sz + int'(m_infl)) < int'(DEPTH));
    chk("rnd_req",   {31'b0, imem_req},  {31'b0, ereq});
    chk("rnd_addr",  imem_addr,          m_pc);
    chk("rnd_valid", {31'b0, out_valid}, {31'b0, sz != 0});
    chk("rnd_pc",    out_pc,             (sz != 0) ? mq[0].pc : 32'h0);
    chk("rnd_instr", out_instr,          (sz != 0) ? mq[0].instr : 32'h0);
`ifdef FETCH_UNIT_PERF_EN
    chk("rnd_perf_fetched", perf_fetched, m_fetched);
    chk("rnd_perf_flushed", perf_flushed, m_flushed);
`endif
  endtask

  // Cycle driver: inputs at negedge, memory answers the previous cycle's request
  logic        prev_req = 1'b0;
  logic [31:0] prev_addr = '0;

  task automatic run_cycle(input bit rst, input bit rdy, input bit rv,
                           input logic [31:0] ra, input bit inj);
    @(negedge clk);
    reset          = rst;
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_addr  = ra;
    imem_rvalid    = prev_req | inj;
    imem_rdata     = inj ? 32'hDEAD_BEEF : (prev_req ? mem_word(prev_addr) : 32'h0);
    #1;
  endtask

  task automatic end_cycle();
    prev_req  = imem_req;
    prev_addr = imem_addr;
    model_step();
  endtask

  typedef struct {
    bit          rst; bit rdy; bit rv; logic [31:0] ra; bit inj; bit chk;
    bit          req; logic [31:0] addr; bit ov; logic [31:0] pc;
  } vec_t;
  vec_t vq[$];

  function automatic vec_t row(bit rdy, bit req, logic [31:0] addr, bit ov, logic [31:0] pc);
    vec_t v;
    v.rst = 0; v.rdy = rdy; v.rv = 0; v.ra = '0; v.inj = 0; v.chk = 1;
    v.req = req; v.addr = addr; v.ov = ov; v.pc = pc;
    return v;
  endfunction

  function automatic vec_t rst_row(bit chk_en);
    vec_t v;
    v = row(1'b1, 1'b0, RST_A, 1'b0, 32'h0);
    v.rst = 1; v.chk = chk_en;
    return v;
  endfunction

  function automatic vec_t redir_row(bit rdy, logic [31:0] ra, logic [31:0] addr, bit ov, logic [31:0] pc);
    vec_t v;
    v = row(rdy, 1'b0, addr, ov, pc);
    v.rv = 1; v.ra = ra;
    return v;
  endfunction

  initial begin
    vec_t v;
    vec_t inj_v;
    reset = 1; out_ready = 0; redirect_valid = 0; redirect_addr = '0;
    imem_rvalid = 0; imem_rdata = '0;

    // Streaming from reset with out_ready high
    vq.push_back(rst_row(0));
    vq.push_back(rst_row(1));
    vq.push_back(row(1, 1, 32'h00, 0, 32'h0));
    vq.push_back(row(1, 1, 32'h04, 0, 32'h0));
    vq.push_back(row(1, 1, 32'h08, 1, 32'h0));
    vq.push_back(row(1, 1, 32'h0C, 1, 32'h4));
    vq.push_back(row(1, 1, 32'h10, 1, 32'h8));
    vq.push_back(row(1, 1, 32'h14, 1, 32'hC));
    // Backpressure: fills to DEPTH, stalls, then drains in order
    vq.push_back(rst_row(0));
    vq.push_back(rst_row(1));
    vq.push_back(row(0, 1, 32'h00, 0, 32'h0));
    vq.push_back(row(0, 1, 32'h04, 0, 32'h0));
    vq.push_back(row(0, 1, 32'h08, 1, 32'h0));
    vq.push_back(row(0, 1, 32'h0C, 1, 32'h0));
    for (int i = 0; i < 6; i++) vq.push_back(row(0, 0, 32'h10, 1, 32'h0));
    vq.push_back(row(1, 0, 32'h10, 1, 32'h0));
    vq.push_back(row(1, 1, 32'h10, 1, 32'h4));
    vq.push_back(row(1, 1, 32'h14, 1, 32'h8));
    vq.push_back(row(1, 1, 32'h18, 1, 32'hC));
    vq.push_back(row(1, 1, 32'h1C, 1, 32'h10));
    // Redirect with two queued, one in flight, and a simultaneous head handshake
    vq.push_back(rst_row(0));
    vq.push_back(rst_row(1));
    vq.push_back(row(0, 1, 32'h00, 0, 32'h0));
    vq.push_back(row(0, 1, 32'h04, 0, 32'h0));
    vq.push_back(row(0, 1, 32'h08, 1, 32'h0));
    vq.push_back(redir_row(1, 32'h103, 32'h0C, 1, 32'h0));
    vq.push_back(row(1, 1, 32'h100, 0, 32'h0));
    vq.push_back(row(1, 1, 32'h104, 0, 32'h0));
    vq.push_back(row(1, 1, 32'h108, 1, 32'h100));
    // PC wrap at the top of the address space
    vq.push_back(redir_row(1, 32'hFFFF_FFFE, 32'h10C, 1, 32'h104));
    vq.push_back(row(1, 1, 32'hFFFF_FFFC, 0, 32'h0));
    vq.push_back(row(1, 1, 32'h0000_0000, 0, 32'h0));
    vq.push_back(row(1, 1, 32'h0000_0004, 1, 32'hFFFF_FFFC));
    vq.push_back(row(1, 1, 32'h0000_0008, 1, 32'h0));
    // One-cycle reset mid-stream, stray response right after release
    vq.push_back(rst_row(0));
    inj_v = row(1, 1, 32'h00, 0, 32'h0);
    inj_v.inj = 1;
    vq.push_back(inj_v);
    vq.push_back(row(1, 1, 32'h04, 0, 32'h0));
    vq.push_back(row(1, 1, 32'h08, 1, 32'h0));

    // Settle the design out of its unknown power-up state
    run_cycle(1, 0, 0, '0, 0); end_cycle();
    run_cycle(1, 0, 0, '0, 0); end_cycle();

    nop_mode = 1;
    for (int i = 0; i < vq.size(); i++) begin
      v = vq[i];
      run_cycle(v.rst, v.rdy, v.rv, v.ra, v.inj);
      if (v.chk) begin
        chk($sformatf("vec%0d_req", i),   {31'b0, imem_req},  {31'b0, v.req});
        chk($sformatf("vec%0d_addr", i),  imem_addr,          v.addr);
        chk($sformatf("vec%0d_valid", i), {31'b0, out_valid}, {31'b0, v.ov});
        chk($sformatf("vec%0d_pc", i),    out_pc,             v.pc);
        chk($sformatf("vec%0d_instr", i), out_instr,          v.ov ? INSTR_NOP : 32'h0);
      end
      end_cycle();
    end

    // Back-to-back redirects: the second target wins
    nop_mode = 0;
    run_cycle(1, 1, 0, '0, 0); end_cycle();
    for (int i = 0; i < 3; i++) begin
      run_cycle(0, 1, 0, '0, 0); end_cycle();
    end
    run_cycle(0, 1, 1, 32'h2001, 0); end_cycle();
    run_cycle(0, 1, 1, 32'h3002, 0);
    chk("b2b_req0",   {31'b0, imem_req},  32'h0);
    chk("b2b_addr0",  imem_addr,          32'h2000);
    chk("b2b_valid0", {31'b0, out_valid}, 32'h0);
    end_cycle();
    run_cycle(0, 1, 0, '0, 0);
    chk("b2b_req1",   {31'b0, imem_req},  32'h1);
    chk("b2b_addr1",  imem_addr,          32'h3000);
    chk("b2b_valid1", {31'b0, out_valid}, 32'h0);
    end_cycle();
    run_cycle(0, 1, 0, '0, 0);
    chk("b2b_addr2",  imem_addr,          32'h3004);
    chk("b2b_valid2", {31'b0, out_valid}, 32'h0);
    end_cycle();
    run_cycle(0, 1, 0, '0, 0);
    chk("b2b_valid3", {31'b0, out_valid}, 32'h1);
    chk("b2b_pc3",    out_pc,             32'h3000);
    chk("b2b_instr3", out_instr,          mem_word(32'h3000));
    end_cycle();

    // Random traffic against the reference model
    for (int i = 0; i < 2500; i++) begin
      bit          rst;
      bit          rv;
      bit          rdy;
      logic [31:0] ra;
      rst = ($urandom_range(0, 199) == 0);
      rv  = ($urandom_range(0, 11) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      ra  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                        : 32'($urandom);
      run_cycle(rst, rdy, rv, ra, 0);
      model_check();
      end_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
